// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// rtl/eth_phy_10g_rx_link_ctrl.sv - 10G BASE-R receive link bring-up and supervision controller
//
// Sequences the RX PHY through reset, block-lock acquisition and a lock stability
// check before qualifying the MAC receive output. Retrains on lock timeout or
// persistent high BER, steers PRBS31 checker mode and keeps saturating statistics.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   cfg_enable, cfg_prbs31_req      run bring-up / request PRBS31 checker mode
//   stat_clear                      zero all statistics counters
//   rx_block_lock, rx_high_ber,
//   rx_status, rx_error_count       PHY status inputs
//   rx_bad_block, rx_error_bad_fcs,
//   rx_start_packet                 MAC event strobes
//   phy_rx_rst, rx_prbs31_enable,
//   mac_rx_enable, link_up,
//   link_state                      registered control/status outputs
//   prbs_err_accum .. pkt_count     saturating statistics counters
module eth_phy_10g_rx_link_ctrl #(
   parameter int RESET_PULSE_CYCLES  = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int HIGH_BER_CYCLES     = 4096,
   parameter int TIMER_WIDTH         = 20,
   parameter int STAT_WIDTH          = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_enable,
   input  logic                  cfg_prbs31_req,
   input  logic                  stat_clear,
   input  logic                  rx_block_lock,
   input  logic                  rx_high_ber,
   input  logic                  rx_status,
   input  logic [6:0]            rx_error_count,
   input  logic                  rx_bad_block,
   input  logic                  rx_error_bad_fcs,
   input  logic [1:0]            rx_start_packet,
   output logic                  phy_rx_rst,
   output logic                  rx_prbs31_enable,
   output logic                  mac_rx_enable,
   output logic                  link_up,
   output logic [2:0]            link_state,
   output logic [STAT_WIDTH-1:0] prbs_err_accum,
   output logic [STAT_WIDTH-1:0] link_down_count,
   output logic [STAT_WIDTH-1:0] retrain_count,
   output logic [STAT_WIDTH-1:0] bad_block_count,
   output logic [STAT_WIDTH-1:0] bad_fcs_count,
   output logic [STAT_WIDTH-1:0] pkt_count
);

   typedef enum logic [2:0] {
      ST_DISABLED  = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_UP        = 3'd4,
      ST_PRBS      = 3'd5
   } state_t;

   localparam logic [TIMER_WIDTH-1:0] RST_LAST  = TIMER_WIDTH'(RESET_PULSE_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] LOCK_LAST = TIMER_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] STAB_LAST = TIMER_WIDTH'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] BER_LAST  = TIMER_WIDTH'(HIGH_BER_CYCLES - 1);
   localparam logic [STAT_WIDTH-1:0]  STAT_MAX  = '1;
   localparam int SW1 = STAT_WIDTH + 1;
   // Wide enough for accumulator plus a full 7-bit error count without overflow.
   localparam int AW  = ((STAT_WIDTH > 7) ? STAT_WIDTH : 7) + 1;

   state_t                 state, nxt_state;
   logic [TIMER_WIDTH-1:0] timer, nxt_timer;
   logic                   retrain;
   logic                   link_lost;
   logic [1:0]             pkt_inc;
   logic [AW-1:0]          prbs_sum;
   logic [STAT_WIDTH-1:0]  prbs_sat;

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v,
                                                     input logic [1:0] d);
      logic [SW1-1:0] s;
      s = {1'b0, v} + SW1'(d);
      return s[STAT_WIDTH] ? STAT_MAX : s[STAT_WIDTH-1:0];
   endfunction

   always_comb begin
      nxt_state = state;
      nxt_timer = timer;
      retrain   = 1'b0;
      if (!cfg_enable) begin
         nxt_state = ST_DISABLED;
         nxt_timer = '0;
      end else begin
         case (state)
            ST_DISABLED: begin
               nxt_state = ST_RESET;
               nxt_timer = '0;
            end
            ST_RESET: begin
               if (timer == RST_LAST) begin
                  nxt_state = ST_WAIT_LOCK;
                  nxt_timer = '0;
               end else begin
                  nxt_timer = timer + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock is checked first so it wins over a same-cycle timeout.
               if (rx_block_lock) begin
                  nxt_state = ST_STABLE;
                  nxt_timer = '0;
               end else if (timer == LOCK_LAST) begin
                  nxt_state = ST_RESET;
                  nxt_timer = '0;
                  retrain   = 1'b1;
               end else begin
                  nxt_timer = timer + 1'b1;
               end
            end
            ST_STABLE: begin
               if (!rx_block_lock || rx_high_ber) begin
                  nxt_state = ST_WAIT_LOCK;
                  nxt_timer = '0;
               end else if (timer == STAB_LAST) begin
                  // Without rx_status the timer parks here until the PHY reports good.
                  if (rx_status) begin
                     nxt_state = cfg_prbs31_req ? ST_PRBS : ST_UP;
                     nxt_timer = '0;
                  end
               end else begin
                  nxt_timer = timer + 1'b1;
               end
            end
            ST_UP: begin
               if (!rx_block_lock) begin
                  nxt_state = ST_WAIT_LOCK;
                  nxt_timer = '0;
               end else if (rx_high_ber && timer == BER_LAST) begin
                  nxt_state = ST_RESET;
                  nxt_timer = '0;
                  retrain   = 1'b1;
               end else if (cfg_prbs31_req) begin
                  nxt_state = ST_PRBS;
                  nxt_timer = '0;
               end else begin
                  // Timer tracks the length of the current high-BER run only.
                  nxt_timer = rx_high_ber ? timer + 1'b1 : '0;
               end
            end
            ST_PRBS: begin
               nxt_timer = '0;
               if (!cfg_prbs31_req) nxt_state = ST_WAIT_LOCK;
            end
            default: begin
               nxt_state = ST_DISABLED;
               nxt_timer = '0;
            end
         endcase
      end
   end

   assign link_lost  = (state == ST_UP) && (nxt_state != ST_UP);
   assign pkt_inc    = {1'b0, rx_start_packet[0]} + {1'b0, rx_start_packet[1]};
   assign prbs_sum   = AW'(prbs_err_accum) + AW'(rx_error_count);
   assign prbs_sat   = (prbs_sum > AW'(STAT_MAX)) ? STAT_MAX : prbs_sum[STAT_WIDTH-1:0];
   assign link_state = state;

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_DISABLED;
         timer            <= '0;
         phy_rx_rst       <= 1'b1;
         rx_prbs31_enable <= 1'b0;
         mac_rx_enable    <= 1'b0;
         link_up          <= 1'b0;
      end else begin
         state            <= nxt_state;
         timer            <= nxt_timer;
         phy_rx_rst       <= (nxt_state == ST_DISABLED) || (nxt_state == ST_RESET);
         rx_prbs31_enable <= (nxt_state == ST_PRBS);
         mac_rx_enable    <= (nxt_state == ST_UP);
         link_up          <= (nxt_state == ST_UP);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || stat_clear) begin
         prbs_err_accum  <= '0;
         link_down_count <= '0;
         retrain_count   <= '0;
         bad_block_count <= '0;
         bad_fcs_count   <= '0;
         pkt_count       <= '0;
      end else begin
         if (link_lost) link_down_count <= sat_inc(link_down_count, 2'd1);
         if (retrain)   retrain_count   <= sat_inc(retrain_count, 2'd1);
         if (cfg_enable && state == ST_UP) begin
            if (rx_bad_block)     bad_block_count <= sat_inc(bad_block_count, 2'd1);
            if (rx_error_bad_fcs) bad_fcs_count   <= sat_inc(bad_fcs_count, 2'd1);
            pkt_count <= sat_inc(pkt_count, pkt_inc);
         end
         if (state != ST_PRBS && nxt_state == ST_PRBS)
            prbs_err_accum <= '0;
         else if (cfg_enable && state == ST_PRBS)
            prbs_err_accum <= prbs_sat;
      end
   end

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// tb/tb_eth_phy_10g_rx_link_ctrl.sv - directed self-checking bench for eth_phy_10g_rx_link_ctrl
module tb_eth_phy_10g_rx_link_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, cfg_enable, cfg_prbs31_req, stat_clear;
   logic       rx_block_lock, rx_high_ber, rx_status, rx_bad_block, rx_error_bad_fcs;
   logic [6:0] rx_error_count;
   logic [1:0] rx_start_packet;

   logic        a_rst, a_prbs_en, a_mac_en, a_up;
   logic [2:0]  a_state;
   logic [15:0] a_prbs, a_ldown, a_retrain, a_bblk, a_bfcs, a_pkt;
   logic        b_rst, b_prbs_en, b_mac_en, b_up;
   logic [2:0]  b_state;
   logic [3:0]  b_prbs, b_ldown, b_retrain, b_bblk, b_bfcs, b_pkt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   eth_phy_10g_rx_link_ctrl #(.LOCK_TIMEOUT_CYCLES(100), .STAT_WIDTH(16)) u_a (
      .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_prbs31_req(cfg_prbs31_req),
      .stat_clear(stat_clear), .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
      .rx_status(rx_status), .rx_error_count(rx_error_count), .rx_bad_block(rx_bad_block),
      .rx_error_bad_fcs(rx_error_bad_fcs), .rx_start_packet(rx_start_packet),
      .phy_rx_rst(a_rst), .rx_prbs31_enable(a_prbs_en), .mac_rx_enable(a_mac_en),
      .link_up(a_up), .link_state(a_state), .prbs_err_accum(a_prbs),
      .link_down_count(a_ldown), .retrain_count(a_retrain), .bad_block_count(a_bblk),
      .bad_fcs_count(a_bfcs), .pkt_count(a_pkt));

   eth_phy_10g_rx_link_ctrl #(.LOCK_TIMEOUT_CYCLES(100), .STAT_WIDTH(4)) u_b (
      .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_prbs31_req(cfg_prbs31_req),
      .stat_clear(stat_clear), .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
      .rx_status(rx_status), .rx_error_count(rx_error_count), .rx_bad_block(rx_bad_block),
      .rx_error_bad_fcs(rx_error_bad_fcs), .rx_start_packet(rx_start_packet),
      .phy_rx_rst(b_rst), .rx_prbs31_enable(b_prbs_en), .mac_rx_enable(b_mac_en),
      .link_up(b_up), .link_state(b_state), .prbs_err_accum(b_prbs),
      .link_down_count(b_ldown), .retrain_count(b_retrain), .bad_block_count(b_bblk),
      .bad_fcs_count(b_bfcs), .pkt_count(b_pkt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int bound);
      int n = 0;
      while (a_state !== s && n < bound) begin
         tick();
         n++;
      end
      chk(tag, {29'd0, a_state}, {29'd0, s});
   endtask

   initial begin
      int n_rst;
      rst_n = 1'b0; cfg_enable = 1'b0; cfg_prbs31_req = 1'b0; stat_clear = 1'b0;
      rx_block_lock = 1'b0; rx_high_ber = 1'b0; rx_status = 1'b0; rx_bad_block = 1'b0;
      rx_error_bad_fcs = 1'b0; rx_error_count = 7'd0; rx_start_packet = 2'b00;
      tick(); tick();

      chk("rst_state", a_state, 0);
      chk("rst_phy_rx_rst", a_rst, 1);
      chk("rst_link_up", a_up, 0);
      chk("rst_mac_en", a_mac_en, 0);
      chk("rst_prbs_en", a_prbs_en, 0);
      chk("rst_pkt", a_pkt, 0);
      chk("rst_retrain", a_retrain, 0);

      // Bring-up with lock and status held good.
      rst_n = 1'b1; cfg_enable = 1'b1; rx_block_lock = 1'b1; rx_status = 1'b1;
      tick();
      chk("t1_reset_entry", a_state, 1);
      n_rst = 1;
      while (a_state == 3'd1 && n_rst < 100) begin
         tick();
         if (a_state == 3'd1) n_rst++;
      end
      chk("t1_reset_pulse_len", n_rst, 16);
      chk("t1_wait_lock", a_state, 2);
      chk("t1_phy_rst_low", a_rst, 0);
      tick();
      chk("t1_stable", a_state, 3);
      repeat (1023) tick();
      chk("t1_still_stable", a_state, 3);
      chk("t1_not_up_yet", a_up, 0);
      tick();
      chk("t1_up", a_state, 4);
      chk("t1_link_up", a_up, 1);
      chk("t1_mac_en", a_mac_en, 1);

      // Packet and FCS statistics, then clear racing an increment.
      rx_start_packet = 2'b11; rx_error_bad_fcs = 1'b1;
      tick(); tick();
      rx_error_bad_fcs = 1'b0;
      tick();
      rx_start_packet = 2'b01;
      tick();
      rx_start_packet = 2'b00;
      chk("t4_pkt", a_pkt, 7);
      chk("t4_fcs", a_bfcs, 2);
      chk("t4_bblk", a_bblk, 0);
      stat_clear = 1'b1; rx_start_packet = 2'b11;
      tick();
      stat_clear = 1'b0; rx_start_packet = 2'b00;
      chk("t4_clear_pkt", a_pkt, 0);
      chk("t4_clear_fcs", a_bfcs, 0);

      // Bad-block saturation in a narrow counter.
      rx_bad_block = 1'b1;
      repeat (20) tick();
      rx_bad_block = 1'b0;
      chk("t5_bblk_sat4", b_bblk, 15);
      chk("t5_bblk_w16", a_bblk, 20);

      // High BER: a 4095-cycle run survives, a 4096-cycle run retrains.
      rx_high_ber = 1'b1;
      repeat (4095) tick();
      rx_high_ber = 1'b0;
      tick();
      chk("t3_short_run_up", a_state, 4);
      chk("t3_short_run_retrain", a_retrain, 0);
      rx_high_ber = 1'b1;
      repeat (4095) tick();
      chk("t3_long_run_pre", a_state, 4);
      tick();
      rx_high_ber = 1'b0;
      chk("t3_retrain_state", a_state, 1);
      chk("t3_link_up_drop", a_up, 0);
      chk("t3_mac_en_drop", a_mac_en, 0);
      chk("t3_link_down", a_ldown, 1);
      chk("t3_retrain", a_retrain, 1);
      wait_state("t3_back_up", 3'd4, 2000);

      // PRBS31 mode with accumulator saturation.
      cfg_prbs31_req = 1'b1; rx_error_count = 7'd100;
      tick();
      chk("t6_prbs_state", a_state, 5);
      chk("t6_prbs_en", a_prbs_en, 1);
      chk("t6_mac_en", a_mac_en, 0);
      chk("t6_link_down", a_ldown, 2);
      chk("t6_accum_entry", a_prbs, 0);
      tick();
      chk("t6_accum_first", a_prbs, 100);
      rx_block_lock = 1'b0;
      repeat (999) tick();
      rx_block_lock = 1'b1;
      chk("t6_lock_loss_ignored", a_state, 5);
      chk("t6_accum_sat16", a_prbs, 65535);
      chk("t6_accum_sat4", b_prbs, 15);
      cfg_prbs31_req = 1'b0; rx_error_count = 7'd0;
      tick();
      chk("t6_exit_wait_lock", a_state, 2);
      chk("t6_prbs_en_off", a_prbs_en, 0);
      tick();
      chk("t6_stable", a_state, 3);
      cfg_enable = 1'b0;
      tick();
      chk("t6_disabled", a_state, 0);
      chk("t6_phy_rst_high", a_rst, 1);
      chk("t6_retrain_kept", a_retrain, 1);

      // Lock timeout retraining with lock held low.
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      chk("t2_cleared_accum", a_prbs, 0);
      chk("t2_cleared_ldown", a_ldown, 0);
      rx_block_lock = 1'b0; rx_bad_block = 1'b1; cfg_enable = 1'b1;
      tick();
      chk("t2_reset_entry", a_state, 1);
      for (int r = 0; r < 3; r++) begin
         repeat (115) tick();
         chk("t2_wait_lock_last", a_state, 2);
         tick();
         chk("t2_reset_again", a_state, 1);
      end
      rx_bad_block = 1'b0;
      chk("t2_retrain", a_retrain, 3);
      chk("t2_link_up", a_up, 0);
      chk("t2_bblk_not_up_a", a_bblk, 0);
      chk("t2_bblk_not_up_b", b_bblk, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/eth_phy_10g_rx_link_ctrl.md
Name: eth_phy_10g_rx_link_ctrl

Overview:
Link bring-up and supervision controller for the 10G BASE-R MAC/PHY receive path. It sequences the receive PHY through reset, block-lock acquisition and a stability check, then gates the MAC receive output. It retrains the PHY on lock timeout or persistent high BER, steers PRBS31 test mode, and keeps saturating link and packet statistics.

Parameters:
RESET_PULSE_CYCLES, 16, cycles phy_rx_rst is held high per reset entry (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before retrain (>=2)
LOCK_STABLE_CYCLES, 1024, cycles of continuous lock plus no high BER required before UP (>=1)
HIGH_BER_CYCLES, 4096, consecutive rx_high_ber cycles in UP that force retrain (>=1)
TIMER_WIDTH, 20, width of the shared state timer; must hold the largest cycle parameter
STAT_WIDTH, 16, width of each statistics counter

Ports:
clk  in  1  clock, same domain as the MAC/PHY RX
rst_n  in  1  synchronous reset, active-low
cfg_enable  in  1  1 = run link bring-up; 0 = force DISABLED
cfg_prbs31_req  in  1  request PRBS31 checker mode
stat_clear  in  1  synchronous clear of all statistics counters
rx_block_lock  in  1  PHY block lock
rx_high_ber  in  1  PHY high-BER flag
rx_status  in  1  PHY receive status
rx_error_count  in  7  PHY per-cycle error count; used in PRBS only
rx_bad_block  in  1  MAC bad-block strobe
rx_error_bad_fcs  in  1  MAC bad-FCS strobe
rx_start_packet  in  2  MAC start-of-packet strobes, one per lane
phy_rx_rst  out  1  active-high reset to the MAC/PHY RX instance
rx_prbs31_enable  out  1  PRBS31 checker enable to the PHY
mac_rx_enable  out  1  qualifies the MAC AXI output downstream
link_up  out  1  1 only in UP
link_state  out  3  current state encoding
prbs_err_accum  out  STAT_WIDTH  saturating sum of rx_error_count in PRBS
link_down_count  out  STAT_WIDTH  UP-to-non-UP transitions
retrain_count  out  STAT_WIDTH  entries into RESET from WAIT_LOCK or UP
bad_block_count  out  STAT_WIDTH  rx_bad_block pulses while UP
bad_fcs_count  out  STAT_WIDTH  rx_error_bad_fcs pulses while UP
pkt_count  out  STAT_WIDTH  packets started while UP

Behaviour:
- State encoding: DISABLED=0, RESET=1, WAIT_LOCK=2, STABLE=3, UP=4, PRBS=5. All outputs are registered.
- Reset (rst_n=0 at a clk edge): state DISABLED, timer 0, phy_rx_rst=1, all other outputs 0, all counters 0. Reset overrides everything.
- cfg_enable=0 in any state: go to DISABLED on the next edge. No counter increments, except link_down_count when leaving UP.
- DISABLED: phy_rx_rst=1. When cfg_enable=1, go to RESET with timer=0.
- RESET: phy_rx_rst=1 for exactly RESET_PULSE_CYCLES cycles. At timer==RESET_PULSE_CYCLES-1, go to WAIT_LOCK with timer=0.
- WAIT_LOCK: phy_rx_rst=0. The timer increments every cycle.
  - rx_block_lock=1: go to STABLE, timer=0.
  - Otherwise, at timer==LOCK_TIMEOUT_CYCLES-1: go to RESET and increment retrain_count.
  - Lock wins if both conditions hold in the same cycle.
- STABLE:
  - rx_block_lock=0 or rx_high_ber=1: return to WAIT_LOCK, timer=0.
  - At timer==LOCK_STABLE_CYCLES-1 with rx_status=1: go to PRBS if cfg_prbs31_req, else to UP.
  - If rx_status=0 at that point: the timer holds its value and the state waits.
- UP: mac_rx_enable=1, link_up=1. The timer counts consecutive rx_high_ber cycles and clears whenever rx_high_ber=0.
  - Priority 1, rx_block_lock=0: go to WAIT_LOCK.
  - Priority 2, timer reaches HIGH_BER_CYCLES-1 with rx_high_ber=1: go to RESET and increment retrain_count.
  - Priority 3, cfg_prbs31_req=1: go to PRBS.
  - Any exit from UP increments link_down_count. mac_rx_enable and link_up drop on the same edge as the state change; the downstream consumer discards any partial frame.
- PRBS: rx_prbs31_enable=1, mac_rx_enable=0. Each cycle, prbs_err_accum += rx_error_count, saturating at all-ones. prbs_err_accum is cleared on entry to PRBS.
  - cfg_prbs31_req=0: go to WAIT_LOCK, timer=0.
  - Loss of lock is ignored in PRBS.
- Statistics counters: all saturate at 2^STAT_WIDTH-1 and never wrap.
  - bad_block_count, bad_fcs_count and pkt_count count only when the registered state is UP.
  - pkt_count adds the popcount of rx_start_packet (0, 1 or 2) per cycle.
  - stat_clear=1 zeroes all counters, including prbs_err_accum. It wins over a simultaneous increment (result 0 that cycle).
- Timer: TIMER_WIDTH bits. It resets to 0 on every state change and never wraps within a state.

Test Plan:
1. Reset, cfg_enable=1, rx_block_lock tied 1, rx_status=1, defaults -> phy_rx_rst high for exactly 16 cycles; STABLE entered 1 cycle after WAIT_LOCK; link_up asserts after 1024 STABLE cycles; link_state=4.
2. rx_block_lock tied 0, LOCK_TIMEOUT_CYCLES=100 -> RESET re-entered every 16+100 cycles; retrain_count=3 after 3 timeouts; link_up stays 0.
3. In UP: rx_high_ber pulsed for 4095 cycles then 1 low, then held high for 4096 cycles -> no retrain from the first pulse; RESET after the held run; link_down_count=1 and retrain_count=1.
4. In UP: rx_start_packet=2'b11 for 3 cycles, then 2'b01 once, plus 2 rx_error_bad_fcs pulses -> pkt_count=7, bad_fcs_count=2. stat_clear asserted with a concurrent start -> pkt_count=0.
5. STAT_WIDTH=4, 20 rx_bad_block pulses in UP -> bad_block_count=15 (saturated). Same pulses in WAIT_LOCK -> no count.
6. From UP, cfg_prbs31_req=1 with rx_error_count=100 for 1000 cycles -> rx_prbs31_enable=1, mac_rx_enable=0, prbs_err_accum=65535 (saturated). Deassert the request -> WAIT_LOCK. Drop cfg_enable -> DISABLED next edge with phy_rx_rst=1.
